det_buffer: RTL and testbench

//  Downstream of the HOG/SVM classifier. Consumes the per-window result stream (i_valid, is_person, sw_id).

---
 rtl/det_buffer.sv | 149 ++++++++++++++
 tb/tb_det_buffer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/det_buffer.sv
// Detection buffer: FWFT FIFO of positive window IDs with per-frame counting, overflow and sequence tracking.
// Optional frame tagging of each entry enabled by defining DET_TAG_EN.
module det_buffer #(
    parameter int unsigned SW_W    = 11,
    parameter int unsigned SW_LAST = 1199,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned FRM_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic             is_person,
    input  logic [SW_W-1:0]  sw_id,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [SW_W-1:0]  o_id,
`ifdef DET_TAG_EN
    output logic [FRM_W-1:0] o_tag,
`endif
    output logic             frame_done,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             ovf,
    output logic             seq_err
);

    localparam int unsigned AW = $clog2(DEPTH);
`ifdef DET_TAG_EN
    localparam int unsigned EW = FRM_W + SW_W;
`else
    localparam int unsigned EW = SW_W;
`endif

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t            state, state_nxt;
    logic [EW-1:0]     mem [DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic [EW-1:0]     head, wr_data;
    logic [CNT_W-1:0]  pos_cnt, cnt_base_c, cnt_next_c;
    logic [SW_W-1:0]   exp_id;
    logic              empty, full, push, pop, drop, is_last;
    logic              frame_open_c, frame_close_c;
`ifdef DET_TAG_EN
    logic [FRM_W-1:0]  frm_tag;
`endif

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = o_valid && o_ready;
    assign push    = i_valid && is_person && (!full || pop);
    assign drop    = i_valid && is_person && full && !pop;
    assign is_last = (sw_id == SW_W'(SW_LAST));

    // Head is read straight from storage; gated so idle outputs read zero.
    assign head    = mem[rd_ptr[AW-1:0]];
    assign o_valid = !empty;
    assign o_id    = o_valid ? head[SW_W-1:0] : '0;
`ifdef DET_TAG_EN
    assign o_tag   = o_valid ? head[EW-1:SW_W] : '0;
    assign wr_data = {frm_tag, sw_id};
`else
    assign wr_data = sw_id;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (i_valid && !is_last) state_nxt = S_RUN;
            S_RUN:   if (i_valid && is_last)  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // A window seen in S_IDLE opens a frame, so counting restarts from zero.
    always_comb begin
        frame_open_c  = 1'b0;
        frame_close_c = 1'b0;
        cnt_base_c    = '0;
        case (state)
            S_IDLE: begin
                frame_open_c  = i_valid;
                frame_close_c = i_valid && is_last;
            end
            S_RUN: begin
                cnt_base_c    = pos_cnt;
                frame_close_c = i_valid && is_last;
            end
            default: ;
        endcase
        if (cnt_base_c == {CNT_W{1'b1}}) begin
            cnt_next_c = cnt_base_c;
        end else begin
            cnt_next_c = cnt_base_c + CNT_W'(is_person);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pos_cnt    <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            ovf        <= 1'b0;
            seq_err    <= 1'b0;
            exp_id     <= '0;
`ifdef DET_TAG_EN
            frm_tag    <= '0;
`endif
        end else begin
            frame_done <= 1'b0;
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
            if (i_valid) begin
                pos_cnt <= cnt_next_c;
                exp_id  <= is_last ? '0 : sw_id + SW_W'(1);
                if (sw_id != exp_id) seq_err <= 1'b1;
                if (frame_open_c) begin
                    ovf <= drop;
                end else if (drop) begin
                    ovf <= 1'b1;
                end
            end
            if (frame_close_c) begin
                frame_done <= 1'b1;
                frame_cnt  <= cnt_next_c;
`ifdef DET_TAG_EN
                frm_tag    <= frm_tag + FRM_W'(1);
`endif
            end
        end
    end

endmodule

// File: tb/tb_det_buffer.sv
// Directed bench for det_buffer: vector table for frame/FIFO behaviour plus hand sequences
// for saturation, reset mid-frame, sequence errors and (with DET_TAG_EN) frame tags.
module tb_det_buffer;

    localparam int unsigned SW_W  = 4;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned FRM_W = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_valid, is_person, o_ready;
    logic [SW_W-1:0]  sw_id;
    logic             o_valid, frame_done, ovf, seq_err;
    logic [SW_W-1:0]  o_id;
    logic [CNT_W-1:0] frame_cnt;
`ifdef DET_TAG_EN
    logic [FRM_W-1:0] o_tag;
`endif

    int checks   = 0;
    int failures = 0;

    det_buffer #(
        .SW_W(SW_W), .SW_LAST(7), .DEPTH(4), .CNT_W(CNT_W), .FRM_W(FRM_W)
    ) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .is_person(is_person), .sw_id(sw_id),
        .o_valid(o_valid), .o_ready(o_ready), .o_id(o_id),
`ifdef DET_TAG_EN
        .o_tag(o_tag),
`endif
        .frame_done(frame_done), .frame_cnt(frame_cnt), .ovf(ovf), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic             iv, ip;
        logic [SW_W-1:0]  id;
        logic             rdy;
        logic             ov;
        logic [SW_W-1:0]  oid;
        logic             fd;
        logic [CNT_W-1:0] fc;
        logic             ovf, se;
    } vec_t;

    localparam int NV = 32;
    vec_t vecs [NV];

    function automatic vec_t mk(input int iv, ip, id, rdy, ov, oid, fd, fc, ovf_e, se);
        vec_t v;
        v.iv  = 1'(iv);    v.ip  = 1'(ip);   v.id = SW_W'(id);  v.rdy = 1'(rdy);
        v.ov  = 1'(ov);    v.oid = SW_W'(oid); v.fd = 1'(fd);   v.fc  = CNT_W'(fc);
        v.ovf = 1'(ovf_e); v.se  = 1'(se);
        return v;
    endfunction

    task automatic step(input int iv, ip, id, rdy);
        @(negedge clk);
        i_valid = 1'(iv); is_person = 1'(ip); sw_id = SW_W'(id); o_ready = 1'(rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        // iv ip id rdy | ov oid fd fc ovf se  (outputs just after the edge)
        vecs[0]  = mk(1,0,0,1, 0,0,0,0,0,0);
        vecs[1]  = mk(1,0,1,1, 0,0,0,0,0,0);
        vecs[2]  = mk(1,1,2,1, 1,2,0,0,0,0);
        vecs[3]  = mk(1,0,3,1, 0,0,0,0,0,0);
        vecs[4]  = mk(1,0,4,1, 0,0,0,0,0,0);
        vecs[5]  = mk(1,1,5,1, 1,5,0,0,0,0);
        vecs[6]  = mk(1,0,6,1, 0,0,0,0,0,0);
        vecs[7]  = mk(1,0,7,1, 0,0,1,2,0,0);
        vecs[8]  = mk(0,0,0,1, 0,0,0,2,0,0);
        vecs[9]  = mk(1,1,0,0, 1,0,0,2,0,0);
        vecs[10] = mk(1,1,1,0, 1,0,0,2,0,0);
        vecs[11] = mk(1,1,2,0, 1,0,0,2,0,0);
        vecs[12] = mk(1,1,3,0, 1,0,0,2,0,0);
        vecs[13] = mk(1,1,4,0, 1,0,0,2,1,0);
        vecs[14] = mk(1,1,5,0, 1,0,0,2,1,0);
        vecs[15] = mk(1,0,6,0, 1,0,0,2,1,0);
        vecs[16] = mk(1,0,7,0, 1,0,1,6,1,0);
        vecs[17] = mk(0,0,0,1, 1,1,0,6,1,0);
        vecs[18] = mk(0,0,0,1, 1,2,0,6,1,0);
        vecs[19] = mk(0,0,0,1, 1,3,0,6,1,0);
        vecs[20] = mk(0,0,0,1, 0,0,0,6,1,0);
        vecs[21] = mk(1,1,0,0, 1,0,0,6,0,0);
        vecs[22] = mk(1,1,1,0, 1,0,0,6,0,0);
        vecs[23] = mk(1,1,2,0, 1,0,0,6,0,0);
        vecs[24] = mk(1,1,3,0, 1,0,0,6,0,0);
        vecs[25] = mk(1,1,4,1, 1,1,0,6,0,0);
        vecs[26] = mk(1,1,5,0, 1,1,0,6,1,0);
        vecs[27] = mk(1,0,6,1, 1,2,0,6,1,0);
        vecs[28] = mk(1,1,7,1, 1,3,1,7,1,0);
        vecs[29] = mk(0,0,0,1, 1,4,0,7,1,0);
        vecs[30] = mk(0,0,0,1, 1,7,0,7,1,0);
        vecs[31] = mk(0,0,0,1, 0,0,0,7,1,0);

        rst = 1'b1; i_valid = 1'b0; is_person = 1'b0; sw_id = '0; o_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'({o_valid, o_id, frame_done, frame_cnt, ovf, seq_err}), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            step(int'(vecs[i].iv), int'(vecs[i].ip), int'(vecs[i].id), int'(vecs[i].rdy));
            checks++;
            if ({o_valid, o_id, frame_done, frame_cnt, ovf, seq_err} !=
                {vecs[i].ov, vecs[i].oid, vecs[i].fd, vecs[i].fc, vecs[i].ovf, vecs[i].se}) begin
                failures++;
                $display("FAIL vec%0d: got ov=%0d id=%0d fd=%0d cnt=%0d ovf=%0d se=%0d expected ov=%0d id=%0d fd=%0d cnt=%0d ovf=%0d se=%0d",
                         i, o_valid, o_id, frame_done, frame_cnt, ovf, seq_err,
                         vecs[i].ov, vecs[i].oid, vecs[i].fd, vecs[i].fc, vecs[i].ovf, vecs[i].se);
            end
        end

        // Eight positives into a 3-bit counter must saturate at 7.
        for (int i = 0; i < 8; i++) step(1, 1, i, 1);
        chk("sat_frame_done", int'(frame_done), 1);
        chk("sat_frame_cnt", int'(frame_cnt), 7);
        chk("sat_ovf", int'(ovf), 0);
        step(0, 0, 0, 1);
        chk("sat_drained", int'(o_valid), 0);

        // Reset in the middle of a frame discards buffered entries and the count.
        for (int i = 0; i < 3; i++) step(1, 1, i, 0);
        chk("pre_rst_valid", int'(o_valid), 1);
        @(negedge clk);
        rst = 1'b1; i_valid = 1'b0; is_person = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_o_valid", int'(o_valid), 0);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step(1, int'(i == 1 || i == 6), i, 1);
        chk("post_rst_done", int'(frame_done), 1);
        chk("post_rst_cnt", int'(frame_cnt), 2);
        chk("post_rst_seq", int'(seq_err), 0);
        step(0, 0, 0, 1);

        // Skipped id 2 raises a sticky sequence error.
        begin
            int ids [7] = '{0, 1, 3, 4, 5, 6, 7};
            for (int i = 0; i < 7; i++) begin
                step(1, 0, ids[i], 1);
                if (i == 1) chk("seq_before_gap", int'(seq_err), 0);
                if (i == 2) chk("seq_after_gap", int'(seq_err), 1);
            end
        end
        chk("seq_frame_done", int'(frame_done), 1);
        for (int i = 0; i < 8; i++) step(1, 0, i, 1);
        chk("seq_sticky", int'(seq_err), 1);
        @(negedge clk);
        rst = 1'b1; i_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("seq_rst_clear", int'(seq_err), 0);
        @(negedge clk);
        rst = 1'b0;

`ifdef DET_TAG_EN
        // Five frames, positives in frames 1, 2 and 5: tags 0, 1 and wrapped 0.
        for (int f = 0; f < 5; f++) begin
            for (int i = 0; i < 8; i++) step(1, int'(i == 0 && (f == 0 || f == 1 || f == 4)), i, 0);
        end
        chk("tag_head0", int'(o_tag), 0);
        step(0, 0, 0, 1);
        chk("tag_head1", int'(o_tag), 1);
        step(0, 0, 0, 1);
        chk("tag_wrap", int'(o_tag), 0);
        chk("tag_wrap_valid", int'(o_valid), 1);
        step(0, 0, 0, 1);
        chk("tag_empty", int'(o_tag), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
